regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port among NUM_REQ writeback sources (ALU, load unit, CSR/mul) using round-robin arbitration.

---
 rtl/rf_wb_pkg.sv | 27 ++
 rtl/regfile_wb_arbiter_if.sv | 38 +++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 41 ++++
 rtl/regfile_wb_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/rf_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_pkg
//  Description : Shared widths, request record and pointer helper for the
//                register-file writeback arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_wb_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;
    localparam int RF_NUM_REQ  = 3;

    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wb_req_t;

    // Round-robin successor of a requester index, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter_if
//  Description : Writeback request bus plus register-file write port.
//                master = requesters / register file side, slave = arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if
    import rf_wb_pkg::*;
#(
    parameter int NUM_REQ = RF_NUM_REQ,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int DATA_W  = RF_DATA_W
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rf_stall;
    logic                      WriteEn;
    logic [ADDR_W-1:0]         RsW;
    logic [DATA_W-1:0]         WData;
    logic [ID_W-1:0]           grant_id;

    modport master (
        output req_valid, req_addr, req_data, rf_stall,
        input  req_ready, WriteEn, RsW, WData, grant_id
    );

    modport slave (
        input  req_valid, req_addr, req_data, rf_stall,
        output req_ready, WriteEn, RsW, WData, grant_id
    );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker: first set request at or
//                after the pointer (modulo N) wins; one-hot and encoded out.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  wire logic [N-1:0]  i_req,
    input  wire logic [IW-1:0] i_ptr,
    output logic      [N-1:0]  o_grant,
    output logic      [IW-1:0] o_idx,
    output logic               o_any
);

    // Two passes: indices at/above the pointer first, then the wrapped part.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!o_any && i_req[j] && (j >= int'(i_ptr))) begin
                o_grant[j] = 1'b1;
                o_idx      = IW'(j);
                o_any      = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!o_any && i_req[j]) begin
                o_grant[j] = 1'b1;
                o_idx      = IW'(j);
                o_any      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Round-robin sharing of the single register-file write port
//                among NUM_REQ writeback sources. One registered output
//                stage; writes to x0 are accepted and dropped; rf_stall
//                blocks all grants.
//                Optional macro RF_WB_BYPASS_EN adds two decode bypass
//                compare ports fed from the registered write stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int NUM_REQ = RF_NUM_REQ,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int DATA_W  = RF_DATA_W
) (
    input  wire logic          clk,
    input  wire logic          rstn,
    regfile_wb_arbiter_if.slave bus
`ifdef RF_WB_BYPASS_EN
    ,
    input  wire logic [ADDR_W-1:0] byp_addr1,
    input  wire logic [ADDR_W-1:0] byp_addr2,
    output logic                   byp_hit1,
    output logic                   byp_hit2,
    output logic      [DATA_W-1:0] byp_data1,
    output logic      [DATA_W-1:0] byp_data2
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]    r_ptr;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic [ID_W-1:0]    r_gid;

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_xfer;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_real_wr;
    logic [ID_W-1:0]    w_ptr_nxt;

    // Requests are hidden from the picker while in reset or stalled, so
    // ready stays low and nothing transfers.
    assign w_req = (rstn && !bus.rf_stall) ? bus.req_valid : '0;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr_arbiter (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_xfer)
    );

    assign bus.req_ready = w_grant;
    assign w_sel_addr    = bus.req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
    assign w_sel_data    = bus.req_data[int'(w_idx)*DATA_W +: DATA_W];
    assign w_real_wr     = w_xfer && (w_sel_addr != '0);
    assign w_ptr_nxt     = ID_W'(rr_next(int'(w_idx), NUM_REQ));

    // Pointer advance and registered write stage; x0 transfers only move the pointer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr  <= '0;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_gid  <= '0;
        end else begin
            r_we <= w_real_wr;
            if (w_xfer) begin
                r_ptr <= w_ptr_nxt;
            end
            if (w_real_wr) begin
                r_addr <= w_sel_addr;
                r_data <= w_sel_data;
                r_gid  <= w_idx;
            end
        end
    end

    assign bus.WriteEn  = r_we;
    assign bus.RsW      = r_addr;
    assign bus.WData    = r_data;
    assign bus.grant_id = r_gid;

`ifdef RF_WB_BYPASS_EN
    assign byp_hit1  = r_we && (r_addr != '0) && (r_addr == byp_addr1);
    assign byp_hit2  = r_we && (r_addr != '0) && (r_addr == byp_addr2);
    assign byp_data1 = byp_hit1 ? r_data : '0;
    assign byp_data2 = byp_hit2 ? r_data : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Directed scoreboard bench for regfile_wb_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
    import rf_wb_pkg::*;

    localparam int NR = 3;
    localparam int AW = RF_ADDR_W;
    localparam int DW = RF_DATA_W;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef RF_WB_BYPASS_EN
    logic [AW-1:0] byp_addr1, byp_addr2;
    logic          byp_hit1, byp_hit2;
    logic [DW-1:0] byp_data1, byp_data2;
`endif

    regfile_wb_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
`ifdef RF_WB_BYPASS_EN
        ,
        .byp_addr1 (byp_addr1),
        .byp_addr2 (byp_addr2),
        .byp_hit1  (byp_hit1),
        .byp_hit2  (byp_hit2),
        .byp_data1 (byp_data1),
        .byp_data2 (byp_data2)
`endif
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    gid;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_we;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write presented on the port is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rstn === 1'b1 && bus.WriteEn === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got RsW=%0h WData=%0h expected no write", bus.RsW, bus.WData);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_RsW", bus.RsW, e.addr);
                chk("wr_WData", bus.WData, e.data);
                chk("wr_grant_id", bus.grant_id, e.gid);
            end
        end
    end

    // One cycle: drive requests, check ready/WriteEn at negedge, queue the expected write.
    task automatic step(input string tag, input logic [2:0] v,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                        input logic st, input logic [2:0] exp_rdy);
        exp_t e;
        bus.req_valid = v;
        bus.req_addr  = {a2, a1, a0};
        bus.req_data  = {d2, d1, d0};
        bus.rf_stall  = st;
        @(negedge clk);
        chk({tag, "_ready"}, bus.req_ready, exp_rdy);
        chk({tag, "_we"}, bus.WriteEn, exp_we);
        exp_we = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (exp_rdy[i]) begin
                e.addr = (i == 0) ? a0 : (i == 1) ? a1 : a2;
                e.data = (i == 0) ? d0 : (i == 1) ? d1 : d2;
                e.gid  = 2'(i);
                if (e.addr != '0) begin
                    sb.push_back(e);
                    exp_we = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn          = 1'b0;
        exp_we        = 1'b0;
        bus.req_valid = 3'b111;
        bus.req_addr  = {5'd3, 5'd2, 5'd1};
        bus.req_data  = {32'h33, 32'h22, 32'h11};
        bus.rf_stall  = 1'b0;
`ifdef RF_WB_BYPASS_EN
        byp_addr1 = 5'd7;
        byp_addr2 = 5'd0;
`endif
        // Reset with all requesters valid
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 3'b000);
        chk("rst_we", bus.WriteEn, 1'b0);
        chk("rst_RsW", bus.RsW, 5'd0);
        chk("rst_WData", bus.WData, 32'h0);
        chk("rst_gid", bus.grant_id, 2'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Contention: grants rotate 0,1,2,0 one per cycle
        step("cont0", 3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 3'b001);
        step("cont1", 3'b111, 5'd4, 5'd2, 5'd3, 32'h44, 32'h22, 32'h33, 1'b0, 3'b010);
        step("cont2", 3'b111, 5'd4, 5'd6, 5'd3, 32'h44, 32'h66, 32'h33, 1'b0, 3'b100);
        step("cont3", 3'b111, 5'd4, 5'd6, 5'd8, 32'h44, 32'h66, 32'h88, 1'b0, 3'b001);
        step("cont4", 3'b110, 5'd0, 5'd6, 5'd8, 32'h0,  32'h66, 32'h88, 1'b0, 3'b010);
        step("cont5", 3'b100, 5'd0, 5'd0, 5'd8, 32'h0,  32'h0,  32'h88, 1'b0, 3'b100);

        // Single source, then idle: WriteEn drops, RsW/WData hold
        step("single", 3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 3'b010);
        step("idle0",  3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'b000);
        @(negedge clk);
        chk("hold_we", bus.WriteEn, 1'b0);
        chk("hold_RsW", bus.RsW, 5'd5);
        chk("hold_WData", bus.WData, 32'hDEADBEEF);
        @(posedge clk);
        #1;

        // x0 drop: pointer must move from 0 to 1 without a write
        step("toptr0", 3'b100, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h99, 1'b0, 3'b100);
        step("x0",     3'b001, 5'd0, 5'd0, 5'd0, 32'h1234, 32'h0, 32'h0, 1'b0, 3'b001);
        step("afterx0", 3'b111, 5'd10, 5'd11, 5'd12, 32'h100, 32'h110, 32'h120, 1'b0, 3'b010);

        // Stall two cycles, pointer stays at 2
        step("stall0", 3'b101, 5'd10, 5'd0, 5'd12, 32'h100, 32'h0, 32'h120, 1'b1, 3'b000);
        step("stall1", 3'b101, 5'd10, 5'd0, 5'd12, 32'h100, 32'h0, 32'h120, 1'b1, 3'b000);
        step("unstall", 3'b101, 5'd10, 5'd0, 5'd12, 32'h100, 32'h0, 32'h120, 1'b0, 3'b100);
        step("post0",  3'b001, 5'd10, 5'd0, 5'd0, 32'h100, 32'h0, 32'h0, 1'b0, 3'b001);

        // Wraparound: pointer 1 with only req0 valid, then pointer 1 with 0 and 2 valid
        step("wrap0", 3'b001, 5'd15, 5'd0, 5'd0, 32'h150, 32'h0, 32'h0, 1'b0, 3'b001);
        step("idle1", 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'b000);
        step("skip",  3'b101, 5'd16, 5'd0, 5'd17, 32'h160, 32'h0, 32'h170, 1'b0, 3'b100);
        step("skip2", 3'b001, 5'd16, 5'd0, 5'd0, 32'h160, 32'h0, 32'h0, 1'b0, 3'b001);
        step("idle2", 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'b000);

        // Write to r7, observe bypass in the cycle WriteEn is high
        step("byp", 3'b010, 5'd0, 5'd7, 5'd0, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0, 3'b010);
        bus.req_valid = 3'b000;
        @(negedge clk);
        chk("byp_we", bus.WriteEn, 1'b1);
`ifdef RF_WB_BYPASS_EN
        chk("byp_hit1", byp_hit1, 1'b1);
        chk("byp_data1", byp_data1, 32'hA5A5A5A5);
        chk("byp_hit2", byp_hit2, 1'b0);
        chk("byp_data2", byp_data2, 32'h0);
`endif
        exp_we = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-operation: the in-flight write is discarded
        bus.req_valid = 3'b001;
        bus.req_addr  = {5'd0, 5'd0, 5'd20};
        bus.req_data  = {32'h0, 32'h0, 32'h200};
        @(negedge clk);
        chk("midrst_ready", bus.req_ready, 3'b001);
        @(posedge clk);
        #1;
        chk("midrst_we_pre", bus.WriteEn, 1'b1);
        rstn = 1'b0;
        #1;
        chk("midrst_we", bus.WriteEn, 1'b0);
        chk("midrst_rdy", bus.req_ready, 3'b000);
        bus.req_valid = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        exp_we = 1'b0;
        step("postrst", 3'b101, 5'd22, 5'd0, 5'd23, 32'h220, 32'h0, 32'h230, 1'b0, 3'b001);
        step("idle3",   3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'b000);
        step("idle4",   3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'b000);

        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
